// File: rtl/mem_access_stage.sv
// Memory stage between EX_MEM and MEM_WB: issues loads/stores over a req/ack handshake and stalls upstream meanwhile.
// Optional feature: define MEM_TIMEOUT_EN to enable the WAIT-state timeout and the sticky mem_err flag.
module mem_access_stage #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        m_in,
  input  logic [1:0]        wb_in,
  input  logic [31:0]       r2_in,
  input  logic [31:0]       resALU_in,
  input  logic [3:0]        dest_in,
  output logic [1:0]        wb,
  output logic [31:0]       r2,
  output logic [31:0]       resALU,
  output logic [31:0]       memData,
  output logic [3:0]        dest,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_err,
  output logic [1:0]        state_dbg
);

  // Handshake: dmem_req stays high with addr/we/wdata stable until the cycle dmem_ack is
  // sampled high; the access then completes on that posedge. Ack at any other time is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        mem_op, is_read;
  logic        cap_en;
  logic [31:0] cap_data;
  logic        stall_raw, req_raw;
  logic        timeout_hit;

  assign mem_op  = valid_in & (|m_in);
  assign is_read = (m_in == 2'b01);

  assign r2         = r2_in;
  assign resALU     = resALU_in;
  assign dest       = dest_in;
  assign dmem_we    = m_in[1];
  assign dmem_addr  = resALU_in[ADDR_W+1:2];
  assign dmem_wdata = r2_in;
  assign state_dbg  = state;

  // Gating with rst lets req/stall drop immediately, even if EX_MEM still shows a mem op.
  assign stall    = stall_raw & ~rst;
  assign dmem_req = req_raw & ~rst;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 1'b1;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    wb        = wb_in;
    stall_raw = 1'b0;
    req_raw   = 1'b0;
    cap_en    = 1'b0;
    cap_data  = dmem_rdata;
    case (state)
      IDLE: begin
        if (mem_op) begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          wb        = 2'b00;
          if (dmem_ack) begin
            state_nxt = DONE;
            cap_en    = is_read;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        wb        = 2'b00;
        if (dmem_ack) begin
          state_nxt = DONE;
          cap_en    = is_read;
        end else if (timeout_hit) begin
          state_nxt = DONE;
          cap_en    = 1'b1;
          cap_data  = 32'hDEAD_BEEF;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      memData <= 32'd0;
    end else begin
      state <= state_nxt;
      if (cap_en)
        memData <= cap_data;
    end
  end

endmodule
